// File: rtl/sram_arbiter.sv
// Shares one single-ported synchronous SRAM between the fetch and data requesters.
// Data side has priority; a starvation counter forces a pending fetch through.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  // state | meaning
  // IDLE  | no access issued last cycle, no response due
  // RESP  | access issued last cycle, sram_rdata belongs to owner
  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       grant_data, grant_inst, resp_active;

  // Grants are gated by resetn so nothing reaches the SRAM while in reset.
  always_comb begin
    grant_data = resetn & data_req & ~(inst_req & (starve_cnt == LIMIT));
    grant_inst = resetn & inst_req & ~grant_data;
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign sram_en      = grant_data | grant_inst;
  assign sram_we      = (grant_data & data_wr) ? data_wstrb : 4'b0000;
  assign sram_addr    = grant_data ? data_addr : (grant_inst ? inst_addr : 32'h0);
  assign sram_wdata   = grant_data ? data_wdata : 32'h0;

  assign resp_active  = resetn & (state == RESP);
  assign inst_data_ok = resp_active & (owner == OWN_INST);
  assign data_data_ok = resp_active & (owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? sram_rdata : 32'h0;

  always_comb begin
    state_nxt  = IDLE;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;
    if (grant_data | grant_inst) begin
      state_nxt = RESP;
      owner_nxt = grant_data ? OWN_DATA : OWN_INST;
    end
    if (grant_inst | ~inst_req) begin
      starve_nxt = 4'd0;
    end else if (grant_data && (starve_cnt != LIMIT)) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= OWN_INST;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: stimulus pushes expected responses into a
// queue, an independent monitor pops and compares whenever a data_ok appears.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        owner_data;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sbq[$];

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM model, word-indexed by addr[11:2]; read returns pre-write data.
  logic [31:0] mem [0:1023];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0]   = 32'h02800C0C;  // 0x1C000000
      mem[1]   = 32'h00000013;  // 0x1C000004
      mem[64]  = 32'h12345678;  // 0x100
      mem[128] = 32'hA5A50000;  // 0x200
      loaded   = 1'b1;
    end
    if (sram_en) begin
      sram_rdata <= mem[sram_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr[11:2]][8*b +: 8] = sram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus plus combinational checks; queues the expected response.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [3:0] ds,
                      input logic [31:0] da, input logic [31:0] dd,
                      input logic exp_i, input logic exp_d, input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk); #1;
    resetn = rst; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
    @(negedge clk);
    chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, exp_i});
    chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, exp_d});
    chk("sram_en", {31'b0, sram_en}, {31'b0, exp_i | exp_d});
    chk("sram_we", {28'b0, sram_we}, (exp_d && dw) ? {28'b0, ds} : 32'h0);
    chk("sram_addr", sram_addr, exp_d ? da : (exp_i ? ia : 32'h0));
    if (exp_d && dw) chk("sram_wdata", sram_wdata, dd);
    if (exp_i | exp_d) begin
      e.owner_data = exp_d;
      e.chk_rdata  = !(exp_d && dw);
      e.rdata      = exp_rd;
      e.due        = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic both(input logic rst, input logic exp_i, input logic exp_d, input logic [31:0] rd);
    step(rst, 1'b1, 32'h1C000004, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, exp_i, exp_d, rd);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (inst_data_ok | data_data_ok) begin
      if (sbq.size() == 0) begin
        chk("unexpected_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("resp_owner", {30'b0, inst_data_ok, data_data_ok}, e.owner_data ? 32'h1 : 32'h2);
        chk("resp_latency", cyc, e.due);
        if (e.chk_rdata) chk("resp_rdata", e.owner_data ? data_rdata : inst_rdata, e.rdata);
        chk("nonowner_rdata", e.owner_data ? inst_rdata : data_rdata, 32'h0);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("missing_data_ok", {30'b0, inst_data_ok, data_data_ok}, e.owner_data ? 32'h1 : 32'h2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t discard;
    // Reset held with both requesting, then data wins on release.
    for (int i = 0; i < 3; i++) both(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h1C000000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h12345678);
    idle(1'b1);
    // Single fetch.
    step(1'b1, 1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800C0C);
    idle(1'b1);
    // Partial write then read of the same word.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1234BEEF);
    idle(1'b1);
    // Starvation: D,D,D,D,I repeating.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) both(1'b1, 1'b1, 1'b0, 32'h00000013);
      else            both(1'b1, 1'b0, 1'b1, 32'hA5A50000);
    end
    // Back-to-back owner switch.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1, 32'hA5A50000);
    step(1'b1, 1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800C0C);
    idle(1'b1);
    // Reset mid-op with starve_cnt at 3 and a read outstanding.
    both(1'b1, 1'b0, 1'b1, 32'hA5A50000);
    both(1'b1, 1'b0, 1'b1, 32'hA5A50000);
    both(1'b1, 1'b0, 1'b1, 32'hA5A50000);
    discard = sbq.pop_back();
    both(1'b0, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    // Counter must restart from 0 after reset.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) both(1'b1, 1'b1, 1'b0, 32'h00000013);
      else        both(1'b1, 1'b0, 1'b1, 32'hA5A50000);
    end
    idle(1'b1);
    idle(1'b1);
    chk("queue_drained", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
